// File: rtl/cpu_pkg.sv
// Shared types for the EX-stage forwarding / load-use hazard logic.
// Stage entries shadow just enough of each in-flight instruction to decide forwarding.
package cpu_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  // Full EX entry: sources are kept so forwarding can be decided while it sits in EX.
  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rn;
    logic [REG_IDX_W-1:0] rm;
    logic                 uses_rn;
    logic                 uses_rm;
    logic [REG_IDX_W-1:0] rd;
    logic                 regwrite;
    logic                 memread;
  } stage_info_t;

  // MEM and WB only need to advertise what they will write.
  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 regwrite;
  } wb_info_t;

  localparam stage_info_t EX_BUBBLE = '0;
  localparam wb_info_t    WB_BUBBLE = '0;

  function automatic wb_info_t to_wb_info(input stage_info_t e);
    wb_info_t w;
    w.valid    = e.valid;
    w.rd       = e.rd;
    w.regwrite = e.regwrite;
    return w;
  endfunction

  // XZR reads as zero, so a "write" to it must never be forwarded.
  function automatic logic writes_reg(input wb_info_t e, input logic [REG_IDX_W-1:0] r);
    return e.valid & e.regwrite & (e.rd != XZR) & (e.rd == r);
  endfunction

endpackage

// File: rtl/fwd_sel_unit.sv
// Per-operand forwarding comparator; purely combinational.
// The nearer producer (MEM) shadows an older write of the same register in WB.
import cpu_pkg::*;

module fwd_sel_unit (
  input  logic [REG_IDX_W-1:0] src,
  input  logic                 consume,
  input  wb_info_t             mem,
  input  wb_info_t             wb,
  output fwd_sel_t             sel
);

  always_comb begin
    sel = FWD_REG;
    if (consume && writes_reg(wb, src)) begin
      sel = FWD_WB;
    end
    if (consume && writes_reg(mem, src)) begin
      sel = FWD_MEM;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding selects and load-use stall for the EX stage; selects/stall are combinational.
// A load-use stall holds IF/ID for one cycle while a bubble enters EX; flush overrides it.
import cpu_pkg::*;

module fwd_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  stage_info_t      ex_q;
  stage_info_t      ex_d;
  wb_info_t         mem_q;
  wb_info_t         wb_q;
  logic [CNT_W-1:0] cnt_q;

  logic ex_load;
  logic rn_hit;
  logic rm_hit;

  // A load into XZR produces nothing a consumer could wait on.
  assign ex_load = ex_q.valid & ex_q.memread & (ex_q.rd != XZR);
  assign rn_hit  = id_uses_rn & (id_rn == ex_q.rd);
  assign rm_hit  = id_uses_rm & (id_rm == ex_q.rd);
  assign stall   = id_valid & ex_load & (rn_hit | rm_hit) & ~flush;

  always_comb begin
    ex_d = EX_BUBBLE;
    if (id_valid && !stall && !flush) begin
      ex_d.valid    = 1'b1;
      ex_d.rn       = id_rn;
      ex_d.rm       = id_rm;
      ex_d.uses_rn  = id_uses_rn;
      ex_d.uses_rm  = id_uses_rm;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
    end
  end

  // MEM and WB keep advancing during a stall; only the ID->EX hand-off is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= EX_BUBBLE;
      mem_q <= WB_BUBBLE;
      wb_q  <= WB_BUBBLE;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= to_wb_info(ex_q);
      wb_q  <= mem_q;
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  fwd_sel_t sel_a;
  fwd_sel_t sel_b;

  fwd_sel_unit u_fwd_a (
    .src     (ex_q.rn),
    .consume (ex_q.valid & ex_q.uses_rn),
    .mem     (mem_q),
    .wb      (wb_q),
    .sel     (sel_a)
  );

  fwd_sel_unit u_fwd_b (
    .src     (ex_q.rm),
    .consume (ex_q.valid & ex_q.uses_rm),
    .mem     (mem_q),
    .wb      (wb_q),
    .sel     (sel_b)
  );

  assign fwd_a       = sel_a;
  assign fwd_b       = sel_b;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl with an instruction-history model checked every cycle.
// A narrow stall counter keeps the saturation case short.
module tb_fwd_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             id_valid = 1'b0;
  logic [REG_W-1:0] id_rn = '0;
  logic [REG_W-1:0] id_rm = '0;
  logic [REG_W-1:0] id_rd = '0;
  logic             id_uses_rn = 1'b0;
  logic             id_uses_rm = 1'b0;
  logic             id_regwrite = 1'b0;
  logic             id_memread = 1'b0;
  logic             flush = 1'b0;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rn       (id_rn),
    .id_rm       (id_rm),
    .id_rd       (id_rd),
    .id_uses_rn  (id_uses_rn),
    .id_uses_rm  (id_uses_rm),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall       (stall),
    .stall_count (stall_count)
  );

  // Model: issued[0] is the instruction now in EX, issued[1] one ahead of it, issued[2] two ahead.
  typedef struct {
    bit v;
    int rn;
    int rm;
    int rd;
    bit urn;
    bit urm;
    bit rw;
    bit mr;
  } ins_t;

  ins_t issued[3];
  bit   m_ok = 1'b0;
  int   m_cnt = 0;
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit exp_stall();
    bit reads;
    if (!(id_valid && issued[0].v && issued[0].mr && issued[0].rd != 31)) return 1'b0;
    reads = (id_uses_rn && int'(id_rn) == issued[0].rd) ||
            (id_uses_rm && int'(id_rm) == issued[0].rd);
    return reads && !flush;
  endfunction

  // Nearest earlier writer wins; its distance is exactly the select code.
  function automatic int exp_fwd(input int src, input bit uses);
    if (!issued[0].v || !uses) return 0;
    for (int d = 1; d <= 2; d++) begin
      if (issued[d].v && issued[d].rw && issued[d].rd != 31 && issued[d].rd == src) return d;
    end
    return 0;
  endfunction

  always begin
    ins_t nx;
    bit   st;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 3; i++) issued[i] = '{default: 0};
      m_cnt = 0;
      m_ok  = 1'b1;
    end else if (m_ok) begin
      st = exp_stall();
      if (st && m_cnt < CNT_MAX) m_cnt++;
      nx = '{default: 0};
      if (!st && !flush && id_valid) begin
        nx = '{v: 1'b1, rn: int'(id_rn), rm: int'(id_rm), rd: int'(id_rd),
               urn: id_uses_rn, urm: id_uses_rm, rw: id_regwrite, mr: id_memread};
      end
      issued[2] = issued[1];
      issued[1] = issued[0];
      issued[0] = nx;
    end
  end

  always begin
    @(negedge clk);
    if (m_ok) begin
      chk("model_fwd_a", int'(fwd_a), exp_fwd(issued[0].rn, issued[0].urn));
      chk("model_fwd_b", int'(fwd_b), exp_fwd(issued[0].rm, issued[0].urm));
      chk("model_stall", int'(stall), int'(exp_stall()));
      chk("model_count", int'(stall_count), m_cnt);
    end
  end

  task automatic step(input bit v, input int rn, input int rm, input int rd,
                      input bit urn, input bit urm, input bit rw, input bit mr,
                      input bit fl, input bit rst);
    @(posedge clk);
    #1;
    id_valid    = v;
    id_rn       = rn[REG_W-1:0];
    id_rm       = rm[REG_W-1:0];
    id_rd       = rd[REG_W-1:0];
    id_uses_rn  = urn;
    id_uses_rm  = urm;
    id_regwrite = rw;
    id_memread  = mr;
    flush       = fl;
    reset       = rst;
    @(negedge clk);
  endtask

  task automatic nop(input bit rst = 1'b0);
    step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rst);
  endtask

  task automatic alu(input int rd, input int rn, input int rm, input bit fl = 1'b0, input bit rst = 1'b0);
    step(1'b1, rn, rm, rd, 1'b1, 1'b1, 1'b1, 1'b0, fl, rst);
  endtask

  task automatic ldur(input int rd, input int rn);
    step(1'b1, rn, 0, rd, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) nop();
  endtask

  initial begin
    nop(1'b1);
    nop(1'b1);
    chk("rst_fwd_a", int'(fwd_a), 0);
    chk("rst_fwd_b", int'(fwd_b), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_count", int'(stall_count), 0);
    nop();

    alu(1, 2, 3);
    alu(2, 1, 3);
    nop();
    chk("b2b_fwd_a_mem", int'(fwd_a), 1);
    chk("b2b_fwd_b_reg", int'(fwd_b), 0);
    drain();

    alu(1, 2, 3);
    nop();
    alu(4, 5, 1);
    nop();
    chk("gap1_fwd_b_wb", int'(fwd_b), 2);
    drain();
    alu(1, 2, 3);
    nop();
    nop();
    alu(4, 5, 1);
    nop();
    chk("gap2_fwd_b_reg", int'(fwd_b), 0);
    drain();

    alu(1, 2, 3);
    alu(1, 2, 3);
    alu(6, 1, 1);
    nop();
    chk("dbl_fwd_a_mem", int'(fwd_a), 1);
    chk("dbl_fwd_b_mem", int'(fwd_b), 1);
    drain();
    alu(31, 2, 3);
    alu(31, 2, 3);
    alu(6, 31, 31);
    nop();
    chk("xzr_fwd_a", int'(fwd_a), 0);
    chk("xzr_fwd_b", int'(fwd_b), 0);
    drain();

    ldur(2, 9);
    alu(3, 2, 2);
    chk("lu_stall", int'(stall), 1);
    chk("lu_count_before", int'(stall_count), 0);
    alu(3, 2, 2);
    chk("lu_no_restall", int'(stall), 0);
    chk("lu_count_after", int'(stall_count), 1);
    nop();
    chk("lu_fwd_a_wb", int'(fwd_a), 2);
    chk("lu_fwd_b_wb", int'(fwd_b), 2);
    drain();

    ldur(2, 9);
    step(1'b1, 7, 2, 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("addi_no_stall", int'(stall), 0);
    drain();
    ldur(31, 9);
    alu(3, 31, 31);
    chk("ld_xzr_no_stall", int'(stall), 0);
    drain();

    ldur(2, 9);
    alu(3, 2, 2, 1'b1);
    chk("flush_stall", int'(stall), 0);
    nop();
    chk("flush_count", int'(stall_count), 1);
    chk("flush_bubble_fwd_a", int'(fwd_a), 0);
    drain();

    ldur(2, 9);
    alu(3, 2, 2, 1'b0, 1'b1);
    chk("rst_mid_stall", int'(stall), 1);
    alu(3, 2, 2);
    chk("post_rst_stall", int'(stall), 0);
    chk("post_rst_count", int'(stall_count), 0);
    chk("post_rst_fwd_a", int'(fwd_a), 0);
    chk("post_rst_fwd_b", int'(fwd_b), 0);
    drain();

    for (int i = 0; i < CNT_MAX + 5; i++) begin
      ldur(2, 9);
      alu(3, 2, 2);
    end
    nop();
    chk("sat_count", int'(stall_count), CNT_MAX);
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
